// File: rtl/pattern_history_table_pkg.sv
// Shared definitions for the pattern history table: 2-bit counter values
// and the init/ready FSM state encoding.
package pattern_history_table_pkg;

   localparam logic [1:0] SNT = 2'b00;  // strongly not-taken
   localparam logic [1:0] WNT = 2'b01;  // weakly not-taken
   localparam logic [1:0] WT  = 2'b10;  // weakly taken
   localparam logic [1:0] ST  = 2'b11;  // strongly taken

   typedef enum logic {
      PHT_INIT  = 1'b0,
      PHT_READY = 1'b1
   } pht_state_e;

endpackage

// File: rtl/pattern_history_table_cnvg.sv
// CounterNextValueGenerator: 2-bit saturating counter step toward the
// resolved branch direction.
module pattern_history_table_cnvg
   import pattern_history_table_pkg::*;
(
   input  logic [1:0] cur_i,
   input  logic       taken_i,
   output logic [1:0] next_o
);

   // Step up on taken, down on not-taken, pinned at ST / SNT.
   always_comb begin
      next_o = cur_i;
      if (taken_i) begin
         if (cur_i != ST) next_o = cur_i + 2'd1;
      end else begin
         if (cur_i != SNT) next_o = cur_i - 2'd1;
      end
   end

endmodule

// File: rtl/pattern_history_table.sv
// Pattern history table: 2**INDEX_W two-bit saturating counters with a
// one-cycle predict port and a two-stage read-modify-write update port.
// Optional feature macro PHT_BYPASS_EN: a predict read that hits the entry
// being written by the update stage returns the new value instead of the
// pre-write table contents.
module pattern_history_table
   import pattern_history_table_pkg::*;
#(
   parameter int unsigned INDEX_W    = 10,
   parameter logic [1:0]  INIT_VALUE = WNT
) (
   input  logic               Clk,
   input  logic               Reset,
   output logic               Ready,
   input  logic               PredReq,
   input  logic [INDEX_W-1:0] PredIndex,
   output logic               PredRespValid,
   output logic [1:0]         PredCounter,
   output logic               PredTaken,
   input  logic               UpdValid,
   input  logic [INDEX_W-1:0] UpdIndex,
   input  logic               UpdTaken
);

   localparam int unsigned DEPTH = 1 << INDEX_W;

   logic [1:0]         mem_q [0:DEPTH-1];

   pht_state_e         state_q, state_d;
   logic [INDEX_W-1:0] init_ptr_q, init_ptr_d;

   logic               pred_vld_q, pred_vld_d;
   logic [1:0]         pred_cnt_q, pred_cnt_d;

   logic               u2_vld_q, u2_vld_d;
   logic [INDEX_W-1:0] u2_idx_q, u2_idx_d;
   logic               u2_taken_q, u2_taken_d;
   logic [1:0]         u2_cur_q, u2_cur_d;
   logic [1:0]         u2_next;

   logic               ready;
   logic               pred_acc;
   logic               upd_acc;
   logic [1:0]         pred_rd;
   logic [1:0]         upd_rd;

   logic               we;
   logic [INDEX_W-1:0] waddr;
   logic [1:0]         wdata;

   assign ready    = (state_q == PHT_READY);
   assign pred_acc = PredReq & ready;
   assign upd_acc  = UpdValid & ready;

   pattern_history_table_cnvg u_cnvg (
      .cur_i   (u2_cur_q),
      .taken_i (u2_taken_q),
      .next_o  (u2_next)
   );

   // FSM next state and single write port: the init sweep owns the port in
   // INIT, the U2 stage owns it in READY.
   always_comb begin
      state_d    = state_q;
      init_ptr_d = init_ptr_q;
      we         = 1'b0;
      waddr      = u2_idx_q;
      wdata      = u2_next;
      case (state_q)
         PHT_INIT: begin
            we         = 1'b1;
            waddr      = init_ptr_q;
            wdata      = INIT_VALUE;
            init_ptr_d = init_ptr_q + INDEX_W'(1);
            if (init_ptr_q == '1) state_d = PHT_READY;
         end
         PHT_READY: begin
            we = u2_vld_q;
         end
         default: state_d = PHT_INIT;
      endcase
   end

   // FSM state and sweep pointer; reset restarts the sweep at entry 0.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= PHT_INIT;
         init_ptr_q <= '0;
      end else begin
         state_q    <= state_d;
         init_ptr_q <= init_ptr_d;
      end
   end

   // Table write; a write pending in the reset cycle is dropped.
   always_ff @(posedge Clk) begin
      if (we && !Reset) mem_q[waddr] <= wdata;
   end

   // Read ports: predict (optionally bypassed from U2) and U1 (always
   // forwarded from U2 so back-to-back updates to one entry compose).
   always_comb begin
      pred_rd = mem_q[PredIndex];
`ifdef PHT_BYPASS_EN
      if (u2_vld_q && (u2_idx_q == PredIndex)) pred_rd = u2_next;
`endif
      upd_rd = mem_q[UpdIndex];
      if (u2_vld_q && (u2_idx_q == UpdIndex)) upd_rd = u2_next;
   end

   // Next values for the predict response and the U1->U2 pipeline register.
   always_comb begin
      pred_vld_d = pred_acc;
      pred_cnt_d = pred_acc ? pred_rd : pred_cnt_q;
      u2_vld_d   = upd_acc;
      u2_idx_d   = upd_acc ? UpdIndex : u2_idx_q;
      u2_taken_d = upd_acc ? UpdTaken : u2_taken_q;
      u2_cur_d   = upd_acc ? upd_rd   : u2_cur_q;
   end

   // Predict response register; reset also suppresses any response due next.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         pred_vld_q <= 1'b0;
         pred_cnt_q <= SNT;
      end else begin
         pred_vld_q <= pred_vld_d;
         pred_cnt_q <= pred_cnt_d;
      end
   end

   // U2 stage: valid is reset so in-flight updates are discarded; payload is not.
   always_ff @(posedge Clk) begin
      if (Reset) u2_vld_q <= 1'b0;
      else       u2_vld_q <= u2_vld_d;
      u2_idx_q   <= u2_idx_d;
      u2_taken_q <= u2_taken_d;
      u2_cur_q   <= u2_cur_d;
   end

   assign Ready         = ready;
   assign PredRespValid = pred_vld_q;
   assign PredCounter   = pred_cnt_q;
   assign PredTaken     = pred_cnt_q[1];

endmodule
